mac_ctrl_fsm: RTL and testbench
===============================

# mac_ctrl_fsm

Parametrised control FSM for the quadratic-equation MAC datapath. It generalises the two-mode controller to NUM_MODES selectable modes, each either streaming (one result per input beat) or accumulating (one result per packet). It adds ready/valid input handshaking, a configurable pipeline latency, packet beat counting, drain-before-mode-switch and illegal-mode detection. It sits between the input sample source and the MAC arithmetic, driving its one-hot mode enables and accumulator clear.

## Interface
- NUM_MODES, 2: number of datapath modes (≥2).
- MODE_W, $clog2(NUM_MODES): width of mode select.
- ACC_MASK, 2'b10: bit k=1 means mode k is accumulating; bit k=0 means streaming.
- LATENCY, 1: datapath latency in cycles from accepted beat to result (≥1).
- CNT_W, 16: beat-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  MODE_W  mode select; sampled only on the first beat of a packet.
- valid_in  in  1  input beat valid.
- last_in  in  1  beat is the last of its packet.
- in_ready  out  1  controller accepts a beat this cycle.
- enable  out  NUM_MODES  one-hot datapath mode enable.
- acc_clear  out  1  clear the accumulator; coincides with the first accepted beat in an accumulating mode.
- valid_out  out  1  datapath result valid.
- last_out  out  1  result belongs to the last beat of the packet.
- done  out  1  one-cycle pulse: packet fully drained.
- busy  out  1  state ≠ IDLE.
- count  out  CNT_W  beats accepted in the current or most recent packet.
- mode_err  out  1  one-cycle pulse: illegal mode on a first beat.

## Operation
- Accept: valid_in && in_ready. No beat is accepted while reset is high.
- States (encoded in the package):
  - IDLE: in_ready=1. On accept with mode<NUM_MODES:
    - latch active_mode;
    - count←1;
    - if last_in, go to DRAIN; otherwise go to RUN.
  - IDLE, illegal mode: on accept with mode≥NUM_MODES, drop the beat, pulse mode_err the next cycle, stay in IDLE.
  - RUN: in_ready=1. Each accept increments count, saturating at 2^CNT_W−1. Accept with last_in goes to DRAIN. mode is ignored.
  - DRAIN: in_ready=0. Stay until the final result has issued (LATENCY cycles after the last accept), then go to IDLE.
- enable: combinational one-hot decode of (IDLE ? mode : active_mode). It is gated by (busy | valid_in) and is all-zero for an illegal mode.
- acc_clear: combinational; = accept & IDLE & ACC_MASK[mode] & legal mode.
- Result pipeline: a LATENCY-deep delay line carries {v, l}.
  - Streaming mode: v = accept, l = accept & last_in.
  - Accumulating mode: v = l = accept & last_in.
  - valid_out and last_out are the delay-line output.
- done: registered; high in the first IDLE cycle after DRAIN.
- count: holds through DRAIN and IDLE; cleared to 1 on the next legal first beat.
- Reset (any time, including mid-packet):
  - state=IDLE;
  - delay line flushed;
  - count=0; valid_out=last_out=done=mode_err=0; busy=0;
  - enable=0 and acc_clear=0 unless valid_in is high;
  - in_ready=1.
  - No pending result or done is emitted after reset.

## Timing
- Last beat accepted at cycle t:
  - last_out/valid_out at t+LATENCY;
  - DRAIN spans t+1..t+LATENCY;
  - done and IDLE at t+LATENCY+1;
  - next first beat can be accepted at t+LATENCY+1.
- Streaming beat accepted at cycle c → valid_out at c+LATENCY. There is no gap requirement between beats within a packet.
- Single-beat packet (first beat = last beat) goes IDLE→DRAIN directly.
- valid_in while in DRAIN is not accepted; the source holds it.

## Structure
- Package mac_ctrl_pkg holds:
  - state enum (IDLE, RUN, DRAIN);
  - default ACC_MASK;
  - MODE_STREAM/MODE_ACC constants.
- Sub-module mac_valid_delay: parametrised LATENCY-deep shift register with async reset carrying {valid, last}.

## Test plan
- NUM_MODES=2, LATENCY=1, mode=0, 4 beats with last on the 4th (t=0..3):
  - valid_out at t=1..4;
  - last_out at t=4;
  - done at t=5;
  - count=4;
  - enable=2'b01 throughout.
- mode=1, LATENCY=3, 5 beats starting t=0:
  - acc_clear at t=0 only;
  - single valid_out+last_out at t=7;
  - in_ready=0 at t=5..7;
  - done at t=8.
- mode toggled 0→1 mid-packet: active mode stays 0, enable stays 01, streaming results continue; the next packet uses the new mode.
- NUM_MODES=3, MODE_W=2, mode=3 first beat: beat dropped, mode_err pulse, enable=0, busy stays 0.
- Reset asserted at t=2 during a 6-beat packet, LATENCY=2: no valid_out or done afterwards; all outputs at reset values; a new packet works normally.
- CNT_W=3, 10-beat packet: count saturates at 7.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared types and constants for the MAC control FSM
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Per-mode kind, as stored in one bit of ACC_MASK
  localparam logic MODE_STREAM = 1'b0;
  localparam logic MODE_ACC    = 1'b1;

  localparam logic [1:0] DEFAULT_ACC_MASK = 2'b10;

endpackage

// File: rtl/mac_ctrl_if.sv
// rtl/mac_ctrl_if.sv - sample-source / MAC-datapath control bundle
interface mac_ctrl_if #(
  parameter int NUM_MODES = 2,
  parameter int MODE_W    = $clog2(NUM_MODES),
  parameter int CNT_W     = 16
);
  logic [MODE_W-1:0]    mode;
  logic                 valid_in;
  logic                 last_in;
  logic                 in_ready;
  logic [NUM_MODES-1:0] enable;
  logic                 acc_clear;
  logic                 valid_out;
  logic                 last_out;
  logic                 done;
  logic                 busy;
  logic [CNT_W-1:0]     count;
  logic                 mode_err;

  modport master (
    output mode, valid_in, last_in,
    input  in_ready, enable, acc_clear, valid_out, last_out,
    input  done, busy, count, mode_err
  );

  modport slave (
    input  mode, valid_in, last_in,
    output in_ready, enable, acc_clear, valid_out, last_out,
    output done, busy, count, mode_err
  );
endinterface

// File: rtl/mac_valid_delay.sv
// rtl/mac_valid_delay.sv - LATENCY-deep {valid, last} delay line matching datapath latency
module mac_valid_delay #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_valid,
  input  logic d_last,
  output logic q_valid,
  output logic q_last
);
  logic [LATENCY-1:0] v_sr;
  logic [LATENCY-1:0] l_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_sr <= '0;
      l_sr <= '0;
    end else begin
      v_sr[0] <= d_valid;
      l_sr[0] <= d_last;
      for (int i = 1; i < LATENCY; i++) begin
        v_sr[i] <= v_sr[i-1];
        l_sr[i] <= l_sr[i-1];
      end
    end
  end

  assign q_valid = v_sr[LATENCY-1];
  assign q_last  = l_sr[LATENCY-1];
endmodule

// File: rtl/mac_ctrl_fsm.sv
// rtl/mac_ctrl_fsm.sv - multi-mode MAC controller: handshake, beat count, drain, mode enables
module mac_ctrl_fsm
  import mac_ctrl_pkg::*;
#(
  parameter int                   NUM_MODES = 2,
  parameter int                   MODE_W    = $clog2(NUM_MODES),
  parameter logic [NUM_MODES-1:0] ACC_MASK  = NUM_MODES'(DEFAULT_ACC_MASK),
  parameter int                   LATENCY   = 1,
  parameter int                   CNT_W     = 16
) (
  input logic      clk,
  input logic      reset,
  mac_ctrl_if.slave bus
);
  state_t               state, state_nx;
  logic [MODE_W-1:0]    active_mode;
  logic [MODE_W-1:0]    sel;
  logic [NUM_MODES-1:0] dec;
  logic                 sel_acc;
  logic                 legal;
  logic                 idle;
  logic                 busy;
  logic                 in_ready;
  logic                 accept;
  logic                 d_valid, d_last;
  logic                 q_valid, q_last;
  logic [CNT_W-1:0]     count_q;
  logic                 done_q;
  logic                 mode_err_q;

  assign idle   = (state == ST_IDLE);
  assign busy   = ~idle;
  assign accept = bus.valid_in & in_ready;

  // The live mode input only matters on a first beat; afterwards the latched mode rules.
  assign sel = idle ? bus.mode : active_mode;

  always_comb begin
    dec     = '0;
    sel_acc = 1'b0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (sel == MODE_W'(k)) begin
        dec[k]  = 1'b1;
        sel_acc = (ACC_MASK[k] == MODE_ACC);
      end
    end
  end

  assign legal = |dec;

  always_comb begin
    state_nx = state;
    in_ready = 1'b1;
    case (state)
      ST_IDLE: begin
        if (accept && legal) state_nx = bus.last_in ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (accept && bus.last_in) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        in_ready = 1'b0;
        // The last-flagged result leaving the delay line is the final one of the packet.
        if (q_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      active_mode <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      mode_err_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      done_q     <= (state == ST_DRAIN) && (state_nx == ST_IDLE);
      mode_err_q <= accept & idle & ~legal;
      if (accept && idle && legal) begin
        active_mode <= bus.mode;
        count_q     <= CNT_W'(1);
      end else if (accept && !idle) begin
        count_q <= (&count_q) ? count_q : count_q + 1'b1;
      end
    end
  end

  assign d_last  = accept & legal & bus.last_in;
  assign d_valid = accept & legal & (sel_acc ? bus.last_in : 1'b1);

  mac_valid_delay #(
    .LATENCY (LATENCY)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .d_valid (d_valid),
    .d_last  (d_last),
    .q_valid (q_valid),
    .q_last  (q_last)
  );

  assign bus.in_ready  = in_ready;
  assign bus.enable    = (busy | bus.valid_in) ? dec : '0;
  assign bus.acc_clear = accept & idle & legal & sel_acc;
  assign bus.valid_out = q_valid;
  assign bus.last_out  = q_last;
  assign bus.done      = done_q;
  assign bus.busy      = busy;
  assign bus.count     = count_q;
  assign bus.mode_err  = mode_err_q;
endmodule

// File: tb/tb_mac_ctrl_fsm.sv
// tb/tb_mac_ctrl_fsm.sv - directed scoreboard bench for mac_ctrl_fsm
module tb_mac_ctrl_fsm;
  localparam int             NM  = 3;
  localparam int             MW  = 2;
  localparam int             LAT = 2;
  localparam int             CW  = 3;
  localparam logic [NM-1:0]  AM  = 3'b010;

  typedef struct {
    int due;
    bit last;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  res_t            sb[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  int              m_state = 0;
  logic [MW-1:0]   m_amode = '0;
  logic [CW-1:0]   m_count = '0;
  int              drain_end = 0;
  bit              exp_done = 1'b0;
  bit              exp_err = 1'b0;

  mac_ctrl_if #(.NUM_MODES(NM), .MODE_W(MW), .CNT_W(CW)) bus ();

  mac_ctrl_fsm #(
    .NUM_MODES (NM),
    .MODE_W    (MW),
    .ACC_MASK  (AM),
    .LATENCY   (LAT),
    .CNT_W     (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic apply_reset();
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    bus.mode     = '0;
    reset        = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_enable", bus.enable, 0);
    chk("rst_acc_clear", bus.acc_clear, 0);
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_last_out", bus.last_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mode_err", bus.mode_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.count, 0);
    sb.delete();
    m_state  = 0;
    m_count  = '0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("rst_hold_valid_out", bus.valid_out, 0);
    chk("rst_hold_done", bus.done, 0);
    reset = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance the
  // model at posedge, check registered outputs at the following negedge.
  task automatic step(input bit v, input bit l, input logic [MW-1:0] m);
    bit            rdy, acc, idle, sel_ok, sel_acc, ev, el;
    logic [MW-1:0] sel;
    logic [NM-1:0] en;
    bus.valid_in = v;
    bus.last_in  = l;
    bus.mode     = m;
    #1;
    idle    = (m_state == 0);
    rdy     = (m_state != 2);
    acc     = v && rdy;
    sel     = idle ? m : m_amode;
    sel_ok  = (int'(sel) < NM);
    sel_acc = sel_ok ? AM[sel] : 1'b0;
    en      = '0;
    if (sel_ok && (!idle || v)) en[sel] = 1'b1;
    chk("in_ready", bus.in_ready, rdy);
    chk("enable", bus.enable, en);
    chk("acc_clear", bus.acc_clear, acc && idle && sel_acc);
    @(posedge clk);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (m_state == 2 && cyc == drain_end) begin
      m_state  = 0;
      exp_done = 1'b1;
    end else if (acc) begin
      if (idle && !sel_ok) begin
        exp_err = 1'b1;
      end else begin
        if (idle) begin
          m_amode = m;
          m_count = 1;
        end else if (m_count != '1) begin
          m_count = m_count + 1'b1;
        end
        if (!sel_acc || l) sb.push_back('{cyc + LAT, l});
        if (l) begin
          m_state   = 2;
          drain_end = cyc + LAT;
        end else begin
          m_state = 1;
        end
      end
    end
    cyc++;
    @(negedge clk);
    ev = (sb.size() > 0) && (sb[0].due == cyc);
    el = ev && sb[0].last;
    if (ev) void'(sb.pop_front());
    chk("valid_out", bus.valid_out, ev);
    chk("last_out", bus.last_out, el);
    chk("done", bus.done, exp_done);
    chk("mode_err", bus.mode_err, exp_err);
    chk("busy", bus.busy, m_state != 0);
    chk("count", bus.count, m_count);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    bus.mode     = '0;
    @(negedge clk);
    apply_reset();

    // Streaming mode 0, four beats
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 1, 0);
    idle_steps(LAT + 2);
    chk("stream_count", bus.count, 4);

    // Accumulating mode 1, five beats; then a single-beat packet held through DRAIN
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1); step(1, 1, 1);
    for (int i = 0; i < LAT + 1; i++) step(1, 1, 0);
    idle_steps(LAT + 2);

    // Mode input toggled mid-packet, with gaps; next packet picks up the new mode
    step(1, 0, 0); step(1, 0, 1); step(0, 0, 1); step(1, 0, 2); step(1, 1, 1);
    idle_steps(LAT + 1);
    step(1, 0, 1); step(0, 0, 0); step(1, 1, 0);
    idle_steps(LAT + 2);

    // Illegal mode on a first beat, with and without last
    step(1, 0, 3); step(1, 1, 3); idle_steps(2);

    // Ten-beat streaming packet on mode 2 saturates the 3-bit counter
    for (int i = 0; i < 9; i++) step(1, 0, 2);
    step(1, 1, 2);
    idle_steps(LAT + 2);
    chk("sat_count", bus.count, 7);

    // Reset in the middle of a six-beat packet, then a fresh packet
    step(1, 0, 0); step(1, 0, 0);
    apply_reset();
    idle_steps(LAT + 2);
    step(1, 0, 1); step(1, 0, 1); step(1, 1, 1);
    idle_steps(LAT + 2);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
